tail_light_sequencer: RTL

//  Thunderbird-style tail-light sequencer. Consumer of the slow divided clock
//  (outClock of the clock divider, 2 Hz toggle): treats it as a step strobe and

---
 rtl/tail_light_sequencer_if.sv | 20 ++
 rtl/tail_light_sequencer.sv | 106 ++++++++++
 2 files changed

// File: rtl/tail_light_sequencer_if.sv
// rtl/tail_light_sequencer_if.sv - switch/tick inputs and lamp/state outputs of the tail-light sequencer
interface tail_light_sequencer_if;
  logic       tick;
  logic       left;
  logic       right;
  logic       hazard;
  logic [2:0] lights_l;
  logic [2:0] lights_r;
  logic [2:0] state;

  modport master (
    output tick, left, right, hazard,
    input  lights_l, lights_r, state
  );

  modport slave (
    input  tick, left, right, hazard,
    output lights_l, lights_r, state
  );
endinterface

// File: rtl/tail_light_sequencer.sv
// rtl/tail_light_sequencer.sv - Thunderbird tail-light Moore FSM stepped by the divided-clock strobe
// All logic runs on inClock; tick is only edge-detected, never used as a clock.
module tail_light_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter bit STEP_BOTH   = 1'b0
) (
  input  logic                   inClock,
  input  logic                   reset,
  tail_light_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_e;

  logic [SYNC_STAGES-1:0] l_sync_q;
  logic [SYNC_STAGES-1:0] r_sync_q;
  logic [SYNC_STAGES-1:0] h_sync_q;
  logic                   tick_q;
  state_e                 state_q;
  state_e                 state_d;
  logic [2:0]             lights_l_q;
  logic [2:0]             lights_r_q;
  logic                   l_s;
  logic                   r_s;
  logic                   h_s;
  logic                   hz;
  logic                   step;

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      l_sync_q <= '0;
      r_sync_q <= '0;
      h_sync_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      l_sync_q <= {l_sync_q[SYNC_STAGES-2:0], bus.left};
      r_sync_q <= {r_sync_q[SYNC_STAGES-2:0], bus.right};
      h_sync_q <= {h_sync_q[SYNC_STAGES-2:0], bus.hazard};
      tick_q   <= bus.tick;
    end
  end

  assign l_s  = l_sync_q[SYNC_STAGES-1];
  assign r_s  = r_sync_q[SYNC_STAGES-1];
  assign h_s  = h_sync_q[SYNC_STAGES-1];
  assign hz   = h_s | (l_s & r_s);
  assign step = STEP_BOTH ? (bus.tick ^ tick_q) : (bus.tick & ~tick_q);

  // Every sequence returns through IDLE, so left/right swaps never jump sides.
  always_comb begin
    state_d = state_q;
    if (step) begin
      case (state_q)
        IDLE:    state_d = hz ? LR3 : l_s ? L1 : r_s ? R1 : IDLE;
        L1:      state_d = hz ? LR3 : l_s ? L2 : IDLE;
        L2:      state_d = hz ? LR3 : l_s ? L3 : IDLE;
        R1:      state_d = hz ? LR3 : r_s ? R2 : IDLE;
        R2:      state_d = hz ? LR3 : r_s ? R3 : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  function automatic logic [2:0] left_lamps(input state_e s);
    case (s)
      L1:      left_lamps = 3'b001;
      L2:      left_lamps = 3'b011;
      L3, LR3: left_lamps = 3'b111;
      default: left_lamps = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] right_lamps(input state_e s);
    case (s)
      R1:      right_lamps = 3'b100;
      R2:      right_lamps = 3'b110;
      R3, LR3: right_lamps = 3'b111;
      default: right_lamps = 3'b000;
    endcase
  endfunction

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lights_l_q <= 3'b000;
      lights_r_q <= 3'b000;
    end else if (step) begin
      state_q    <= state_d;
      lights_l_q <= left_lamps(state_d);
      lights_r_q <= right_lamps(state_d);
    end
  end

  assign bus.state    = state_q;
  assign bus.lights_l = lights_l_q;
  assign bus.lights_r = lights_r_q;

endmodule
